key_press_decoder: RTL and testbench

KEY_PRESS_DECODER -- requirements
Module: key_press_decoder

---
 rtl/washer_key_pkg.sv | 15 +
 rtl/key_hold_timer.sv | 37 +++
 rtl/key_press_decoder.sv | 140 ++++++++++++++
 tb/tb_key_press_decoder.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/washer_key_pkg.sv
// Shared constants and state encoding for the washer key press decoder.
// Counter width, default timing and FSM state codes live here.
package washer_key_pkg;

    localparam int CNT_W = 16;
    localparam int unsigned DEF_LONG_CYCLES = 8;
    localparam int unsigned DEF_REPEAT_CYCLES = 4;

    typedef logic [1:0] key_state_t;

    localparam key_state_t ST_IDLE    = 2'd0;
    localparam key_state_t ST_PRESSED = 2'd1;
    localparam key_state_t ST_LONG    = 2'd2;

endpackage

// File: rtl/key_hold_timer.sv
// Loadable saturating up-counter with a terminal-count flag.
// Load forces the count to 1; the count never wraps past all-ones.
module key_hold_timer
    import washer_key_pkg::*;
#(
    parameter int unsigned TARGET = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic load,
    input  logic inc,
    output logic tc
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = CNT_W'(1);
        end else if (inc && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc = (count_q == CNT_W'(TARGET));

endmodule

// File: rtl/key_press_decoder.sv
// Key press decoder: press/short/long pulses and a held level.
// Define KEY_REPEAT_EN to enable auto-repeat pulses while in LONG.
module key_press_decoder
    import washer_key_pkg::*;
#(
    parameter int unsigned LONG_CYCLES   = DEF_LONG_CYCLES,
    parameter int unsigned REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
    input  logic clock,
    input  logic reset,
    input  logic keyin,
    output logic press_pulse,
    output logic short_pulse,
    output logic long_pulse,
    output logic repeat_pulse,
    output logic held
);

    key_state_t state_q, state_d;
    logic press_q, press_d;
    logic short_q, short_d;
    logic long_q, long_d;
    logic held_q, held_d;
    logic hold_load, hold_inc, hold_tc;

    key_hold_timer #(.TARGET(LONG_CYCLES)) u_hold (
        .clock (clock),
        .reset (reset),
        .load  (hold_load),
        .inc   (hold_inc),
        .tc    (hold_tc)
    );

`ifdef KEY_REPEAT_EN
    logic repeat_q, repeat_d;
    logic rep_load, rep_inc, rep_tc;

    key_hold_timer #(.TARGET(REPEAT_CYCLES)) u_repeat (
        .clock (clock),
        .reset (reset),
        .load  (rep_load),
        .inc   (rep_inc),
        .tc    (rep_tc)
    );

    assign repeat_pulse = repeat_q;
`else
    logic unused_repeat_cfg;
    assign unused_repeat_cfg = ^REPEAT_CYCLES;
    assign repeat_pulse = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        press_d   = 1'b0;
        short_d   = 1'b0;
        long_d    = 1'b0;
        hold_load = 1'b0;
        hold_inc  = 1'b0;
`ifdef KEY_REPEAT_EN
        repeat_d  = 1'b0;
        rep_load  = 1'b0;
        rep_inc   = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (keyin) begin
                    state_d   = ST_PRESSED;
                    hold_load = 1'b1;
                    press_d   = 1'b1;
                end
            end
            ST_PRESSED: begin
                if (!keyin) begin
                    state_d = ST_IDLE;
                    short_d = 1'b1;
                end else begin
                    hold_inc = 1'b1;
                    if (hold_tc) begin
                        state_d = ST_LONG;
                        long_d  = 1'b1;
`ifdef KEY_REPEAT_EN
                        rep_load = 1'b1;
`endif
                    end
                end
            end
            ST_LONG: begin
                if (!keyin) begin
                    state_d = ST_IDLE;
                end else begin
                    hold_inc = 1'b1;
`ifdef KEY_REPEAT_EN
                    // Reload on each pulse so the period restarts cleanly.
                    if (rep_tc) begin
                        rep_load = 1'b1;
                        repeat_d = 1'b1;
                    end else begin
                        rep_inc = 1'b1;
                    end
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
        held_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            press_q <= 1'b0;
            short_q <= 1'b0;
            long_q  <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            press_q <= press_d;
            short_q <= short_d;
            long_q  <= long_d;
            held_q  <= held_d;
        end
    end

`ifdef KEY_REPEAT_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            repeat_q <= 1'b0;
        end else begin
            repeat_q <= repeat_d;
        end
    end
`endif

    assign press_pulse = press_q;
    assign short_pulse = short_q;
    assign long_pulse  = long_q;
    assign held        = held_q;

endmodule

// File: tb/tb_key_press_decoder.sv
// Self-checking bench for key_press_decoder (table, directed, random).
// Honours KEY_REPEAT_EN when it is defined for the build.
module tb_key_press_decoder;

    localparam int L = 8;
    localparam int R = 4;
`ifdef KEY_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic keyin = 1'b0;
    logic press_pulse, short_pulse, long_pulse, repeat_pulse, held;

    key_press_decoder #(
        .LONG_CYCLES   (L),
        .REPEAT_CYCLES (R)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .keyin        (keyin),
        .press_pulse  (press_pulse),
        .short_pulse  (short_pulse),
        .long_pulse   (long_pulse),
        .repeat_pulse (repeat_pulse),
        .held         (held)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;
    int run = 0;
    logic [4:0] exp_v;

    typedef struct {
        logic       r;
        logic       k;
        logic [4:0] e;
    } vec_t;

    vec_t tbl[17];

    function automatic logic [4:0] act_v();
        return {press_pulse, short_pulse, long_pulse, repeat_pulse, held};
    endfunction

    // Reference: length of the current unbroken run of pressed samples.
    task automatic model(input logic r, input logic k);
        logic p, s, l, rp, h;
        p = 1'b0; s = 1'b0; l = 1'b0; rp = 1'b0; h = 1'b0;
        if (r) begin
            run = 0;
        end else if (k) begin
            run++;
            p  = (run == 1);
            l  = (run == L + 1);
            rp = REP_EN && (run > L + 1) && (((run - L - 1) % R) == 0);
            h  = 1'b1;
        end else begin
            s   = (run >= 1) && (run <= L);
            run = 0;
        end
        exp_v = {p, s, l, rp, h};
    endtask

    task automatic check(input string name, input logic [4:0] act,
                         input logic [4:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%b exp=%b (p,s,l,rep,held)", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s act=%0d exp=%0d", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic k);
        reset = r;
        keyin = k;
        @(posedge clock);
        #1;
        model(r, k);
    endtask

    initial begin
        int n_press, n_long, n_short;
        logic [4:0] e;
        logic k;

        tbl[0]  = '{1'b1, 1'b0, 5'b00000};
        tbl[1]  = '{1'b0, 1'b1, 5'b10001};
        tbl[2]  = '{1'b0, 1'b1, 5'b00001};
        tbl[3]  = '{1'b0, 1'b1, 5'b00001};
        tbl[4]  = '{1'b0, 1'b0, 5'b01000};
        tbl[5]  = '{1'b0, 1'b0, 5'b00000};
        tbl[6]  = '{1'b0, 1'b1, 5'b10001};
        tbl[7]  = '{1'b0, 1'b0, 5'b01000};
        tbl[8]  = '{1'b0, 1'b1, 5'b10001};
        tbl[9]  = '{1'b0, 1'b1, 5'b00001};
        tbl[10] = '{1'b0, 1'b1, 5'b00001};
        tbl[11] = '{1'b0, 1'b1, 5'b00001};
        tbl[12] = '{1'b0, 1'b1, 5'b00001};
        tbl[13] = '{1'b1, 1'b1, 5'b00000};
        tbl[14] = '{1'b0, 1'b1, 5'b10001};
        tbl[15] = '{1'b0, 1'b0, 5'b01000};
        tbl[16] = '{1'b0, 1'b0, 5'b00000};

        step(1'b1, 1'b0);
        for (int i = 0; i < 17; i++) begin
            step(tbl[i].r, tbl[i].k);
            check($sformatf("table[%0d]", i), act_v(), tbl[i].e);
            check($sformatf("table_model[%0d]", i), act_v(), exp_v);
        end

        for (int i = 0; i <= 20; i++) begin
            step(1'b0, 1'b1);
            e = {i == 0, 1'b0, i == L,
                 REP_EN && (i == 12 || i == 16 || i == 20), 1'b1};
            check($sformatf("long_hold[%0d]", i), act_v(), e);
        end
        step(1'b0, 1'b0);
        check("long_release", act_v(), 5'b00000);

        n_press = 0; n_long = 0; n_short = 0;
        for (int i = 0; i < 70000; i++) begin
            step(1'b0, 1'b1);
            n_press += int'(press_pulse);
            n_long  += int'(long_pulse);
            n_short += int'(short_pulse);
            check("sat_hold", act_v(), exp_v);
        end
        step(1'b0, 1'b0);
        n_short += int'(short_pulse);
        check("sat_release", act_v(), exp_v);
        check_int("sat_press_count", n_press, 1);
        check_int("sat_long_count", n_long, 1);
        check_int("sat_short_count", n_short, 0);

        k = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) < ((i % 400) < 200 ? 3 : 1))
                k = ~k;
            step($urandom_range(0, 149) == 0, k);
            check("random", act_v(), exp_v);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
